// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, ALU, NZCV status register and EX/MEM boundary register.
// Branch target and taken flag are combinational toward IF and the flush logic.
module exe_stage #(
    parameter int unsigned WORD_WIDTH            = 32,
    parameter int unsigned REG_FILE_DEPTH        = 4,
    parameter int unsigned SIGNED_IMM_WIDTH      = 24,
    parameter int unsigned SHIFTER_OPERAND_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             freeze,
    input  logic                             MEM_R_EN_in,
    input  logic                             MEM_W_EN_in,
    input  logic                             WB_EN_in,
    input  logic                             Imm_in,
    input  logic                             B_in,
    input  logic                             S_in,
    input  logic [3:0]                       EX_CMD_in,
    input  logic [3:0]                       Status_Register_in,
    input  logic [REG_FILE_DEPTH-1:0]        Dest_in,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
    input  logic [WORD_WIDTH-1:0]            PC_in,
    input  logic [WORD_WIDTH-1:0]            Val_Rn_in,
    input  logic [WORD_WIDTH-1:0]            Val_Rm_in,
    output logic                             Branch_taken,
    output logic [WORD_WIDTH-1:0]            Branch_Address,
    output logic [3:0]                       status_out,
    output logic [WORD_WIDTH-1:0]            ALU_result_out,
    output logic [WORD_WIDTH-1:0]            Val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0]        Dest_out,
    output logic                             MEM_R_EN_out,
    output logic                             MEM_W_EN_out,
    output logic                             WB_EN_out
);

    localparam int unsigned SHAMT_W = $clog2(WORD_WIDTH);
    localparam int unsigned SUM_W   = WORD_WIDTH + 1;
    localparam int unsigned BR_PAD  = WORD_WIDTH - SIGNED_IMM_WIDTH - 2;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    function automatic logic [WORD_WIDTH-1:0] ror(input logic [WORD_WIDTH-1:0] x,
                                                 input logic [SHAMT_W-1:0]    amt);
        logic [2*WORD_WIDTH-1:0] d;
        d = {x, x} >> amt;
        return d[WORD_WIDTH-1:0];
    endfunction

    logic                  cin;
    logic                  unused_status;
    logic [WORD_WIDTH-1:0] val2;
    logic [WORD_WIDTH-1:0] alu_res;
    logic [SUM_W-1:0]      sum;
    logic                  flag_n, flag_z, flag_c, flag_v;
    logic                  flags_known;
    logic [SHAMT_W-1:0]    shift_amt;
    logic [SHAMT_W-1:0]    rot_amt;

    assign cin           = Status_Register_in[1];
    assign unused_status = ^{Status_Register_in[3:2], Status_Register_in[0]};
    assign shift_amt     = SHAMT_W'(shifter_operand_in[11:7]);
    assign rot_amt       = SHAMT_W'({shifter_operand_in[11:8], 1'b0});

    // Operand-2: rotated imm8, raw 12-bit memory offset, or shifted Rm
    always_comb begin
        val2 = '0;
        if (Imm_in) begin
            val2 = ror(WORD_WIDTH'(shifter_operand_in[7:0]), rot_amt);
        end else if (MEM_R_EN_in || MEM_W_EN_in) begin
            val2 = WORD_WIDTH'(shifter_operand_in[11:0]);
        end else begin
            case (shifter_operand_in[6:5])
                2'b00:   val2 = Val_Rm_in << shift_amt;
                2'b01:   val2 = Val_Rm_in >> shift_amt;
                2'b10:   val2 = $signed(Val_Rm_in) >>> shift_amt;
                default: val2 = ror(Val_Rm_in, shift_amt);
            endcase
        end
    end

    // ALU; subtraction is Rn + ~Val2 + carry so C comes out as NOT borrow
    always_comb begin
        sum         = '0;
        alu_res     = '0;
        flag_c      = 1'b0;
        flag_v      = 1'b0;
        flags_known = 1'b1;
        case (EX_CMD_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, Val_Rn_in} + {1'b0, val2}
                        + SUM_W'((EX_CMD_in == CMD_ADC) ? cin : 1'b0);
                alu_res = sum[WORD_WIDTH-1:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (Val_Rn_in[WORD_WIDTH-1] == val2[WORD_WIDTH-1])
                       && (alu_res[WORD_WIDTH-1] != Val_Rn_in[WORD_WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum     = {1'b0, Val_Rn_in} + {1'b0, ~val2}
                        + SUM_W'((EX_CMD_in == CMD_SBC) ? cin : 1'b1);
                alu_res = sum[WORD_WIDTH-1:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (Val_Rn_in[WORD_WIDTH-1] != val2[WORD_WIDTH-1])
                       && (alu_res[WORD_WIDTH-1] != Val_Rn_in[WORD_WIDTH-1]);
            end
            CMD_AND: alu_res = Val_Rn_in & val2;
            CMD_ORR: alu_res = Val_Rn_in | val2;
            CMD_EOR: alu_res = Val_Rn_in ^ val2;
            default: flags_known = 1'b0;
        endcase
        flag_n = flags_known & alu_res[WORD_WIDTH-1];
        flag_z = flags_known & (alu_res == '0);
    end

    assign Branch_taken   = B_in;
    assign Branch_Address = PC_in
                          + {{BR_PAD{signed_immediate_in[SIGNED_IMM_WIDTH-1]}}, signed_immediate_in, 2'b00};

    // EX/MEM boundary and NZCV register, both held while MEM stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_out     <= '0;
            ALU_result_out <= '0;
            Val_Rm_out     <= '0;
            Dest_out       <= '0;
            MEM_R_EN_out   <= 1'b0;
            MEM_W_EN_out   <= 1'b0;
            WB_EN_out      <= 1'b0;
        end else if (!freeze) begin
            if (S_in) begin
                status_out <= {flag_n, flag_z, flag_c, flag_v};
            end
            ALU_result_out <= alu_res;
            Val_Rm_out     <= Val_Rm_in;
            Dest_out       <= Dest_in;
            MEM_R_EN_out   <= MEM_R_EN_in;
            MEM_W_EN_out   <= MEM_W_EN_in;
            WB_EN_out      <= WB_EN_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: reset, ALU/flags, operand-2 modes, branch target, freeze.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Imm_in, B_in, S_in;
    logic [3:0]  EX_CMD_in;
    logic [3:0]  Status_Register_in;
    logic [3:0]  Dest_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shifter_operand_in;
    logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic [3:0]  status_out;
    logic [31:0] ALU_result_out;
    logic [31:0] Val_Rm_out;
    logic [3:0]  Dest_out;
    logic        MEM_R_EN_out, MEM_W_EN_out, WB_EN_out;

    int n_cmp = 0;
    int n_bad = 0;

    exe_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .freeze              (freeze),
        .MEM_R_EN_in         (MEM_R_EN_in),
        .MEM_W_EN_in         (MEM_W_EN_in),
        .WB_EN_in            (WB_EN_in),
        .Imm_in              (Imm_in),
        .B_in                (B_in),
        .S_in                (S_in),
        .EX_CMD_in           (EX_CMD_in),
        .Status_Register_in  (Status_Register_in),
        .Dest_in             (Dest_in),
        .signed_immediate_in (signed_immediate_in),
        .shifter_operand_in  (shifter_operand_in),
        .PC_in               (PC_in),
        .Val_Rn_in           (Val_Rn_in),
        .Val_Rm_in           (Val_Rm_in),
        .Branch_taken        (Branch_taken),
        .Branch_Address      (Branch_Address),
        .status_out          (status_out),
        .ALU_result_out      (ALU_result_out),
        .Val_Rm_out          (Val_Rm_out),
        .Dest_out            (Dest_out),
        .MEM_R_EN_out        (MEM_R_EN_out),
        .MEM_W_EN_out        (MEM_W_EN_out),
        .WB_EN_out           (WB_EN_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; WB_EN_in = 0;
        Imm_in = 0; B_in = 0; S_in = 0; EX_CMD_in = 4'b0000;
        Status_Register_in = 4'b0000; Dest_in = 4'd0; signed_immediate_in = 24'd0;
        shifter_operand_in = 12'd0; PC_in = 32'd0; Val_Rn_in = 32'd0; Val_Rm_in = 32'd0;
    endtask

    task automatic set_alu(input logic [3:0] cmd, input logic imm, input logic [11:0] sh,
                           input logic [31:0] rn, input logic [31:0] rm, input logic s,
                           input logic wb, input logic [3:0] dest);
        EX_CMD_in = cmd; Imm_in = imm; shifter_operand_in = sh;
        Val_Rn_in = rn; Val_Rm_in = rm; S_in = s; WB_EN_in = wb; Dest_in = dest;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #12;
        check("reset_alu",    ALU_result_out, 32'h0);
        check("reset_status", 32'(status_out), 32'h0);
        check("reset_wb",     32'(WB_EN_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ADD overflow: 0x7FFFFFFF + 1
        set_alu(4'b0010, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 4'd3);
        step();
        check("add_ovf_res",    ALU_result_out, 32'h8000_0000);
        check("add_ovf_status", 32'(status_out), 32'h9);
        check("add_ovf_wb",     32'(WB_EN_out), 32'h1);
        check("add_ovf_dest",   32'(Dest_out), 32'h3);

        // SUB 5-5 -> Z and C
        set_alu(4'b0100, 1'b1, 12'h005, 32'd5, 32'h0, 1'b1, 1'b1, 4'd4);
        step();
        check("sub_res",    ALU_result_out, 32'h0);
        check("sub_status", 32'(status_out), 32'h6);

        // CMP 3,5: flags only, borrow so C=0, N=1
        set_alu(4'b0100, 1'b1, 12'h005, 32'd3, 32'h0, 1'b1, 1'b0, 4'd5);
        step();
        check("cmp_wb",     32'(WB_EN_out), 32'h0);
        check("cmp_res",    ALU_result_out, 32'hFFFF_FFFE);
        check("cmp_status", 32'(status_out), 32'h8);

        // MOV immediate rotate 0xFF ror 4, no flag update
        set_alu(4'b0001, 1'b1, 12'h2FF, 32'h0, 32'h0, 1'b0, 1'b1, 4'd1);
        step();
        check("mov_rot_res",    ALU_result_out, 32'hF000_000F);
        check("mov_rot_status", 32'(status_out), 32'h8);

        // MOV Rm ASR #1
        set_alu(4'b0001, 1'b0, 12'h0C0, 32'h0, 32'h8000_0000, 1'b0, 1'b1, 4'd2);
        step();
        check("mov_asr_res", ALU_result_out, 32'hC000_0000);

        // MOV Rm LSR #4, ROR #8
        set_alu(4'b0001, 1'b0, 12'h220, 32'h0, 32'h8000_00F0, 1'b0, 1'b1, 4'd2);
        step();
        check("mov_lsr_res", ALU_result_out, 32'h0800_000F);
        set_alu(4'b0001, 1'b0, 12'h460, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 4'd2);
        step();
        check("mov_ror_res", ALU_result_out, 32'h7812_3456);

        // ADC with incoming C=1: 1 + 2 + 1
        set_alu(4'b0011, 1'b1, 12'h002, 32'd1, 32'h0, 1'b0, 1'b1, 4'd6);
        Status_Register_in = 4'b0010;
        step();
        check("adc_res", ALU_result_out, 32'd4);
        Status_Register_in = 4'b0000;

        // SBC with C=0: 10 - 3 - 1
        set_alu(4'b0101, 1'b1, 12'h003, 32'd10, 32'h0, 1'b0, 1'b1, 4'd6);
        step();
        check("sbc_res", ALU_result_out, 32'd6);

        // EOR and MVN
        set_alu(4'b1000, 1'b1, 12'h0FF, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1, 4'd6);
        step();
        check("eor_res", ALU_result_out, 32'hFFFF_00FF);
        set_alu(4'b1001, 1'b1, 12'h0FF, 32'h0, 32'h0, 1'b0, 1'b1, 4'd6);
        step();
        check("mvn_res", ALU_result_out, 32'hFFFF_FF00);

        // Load address: Rn + zero-extended 12-bit offset, store data passes through
        set_alu(4'b0010, 1'b0, 12'h123, 32'h0000_1000, 32'hCAFE_BABE, 1'b0, 1'b0, 4'd9);
        MEM_W_EN_in = 1'b1;
        step();
        check("mem_addr",  ALU_result_out, 32'h0000_1123);
        check("mem_wen",   32'(MEM_W_EN_out), 32'h1);
        check("mem_rm",    Val_Rm_out, 32'hCAFE_BABE);
        check("mem_dest",  32'(Dest_out), 32'h9);
        MEM_W_EN_in = 1'b0;

        // Branch target, combinational
        B_in = 1'b1; PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE;
        #1;
        check("br_taken", 32'(Branch_taken), 32'h1);
        check("br_neg",   Branch_Address, 32'h0000_00F8);
        signed_immediate_in = 24'h000004;
        #1;
        check("br_pos",   Branch_Address, 32'h0000_0110);
        B_in = 1'b0;
        #1;
        check("br_clear", 32'(Branch_taken), 32'h0);

        // Freeze two cycles then release
        freeze = 1'b1;
        set_alu(4'b0010, 1'b1, 12'h001, 32'd1, 32'h0, 1'b1, 1'b1, 4'd7);
        step();
        step();
        check("frz_res",    ALU_result_out, 32'h0000_1123);
        check("frz_status", 32'(status_out), 32'h8);
        check("frz_dest",   32'(Dest_out), 32'h9);
        check("frz_wen",    32'(MEM_W_EN_out), 32'h1);
        freeze = 1'b0;
        step();
        check("unfrz_res",    ALU_result_out, 32'd2);
        check("unfrz_status", 32'(status_out), 32'h0);
        check("unfrz_dest",   32'(Dest_out), 32'h7);

        // Bubble leaves status alone
        set_alu(4'b0100, 1'b1, 12'h005, 32'd5, 32'h0, 1'b1, 1'b1, 4'd1);
        step();
        check("pre_bubble_status", 32'(status_out), 32'h6);
        idle_inputs();
        step();
        check("bubble_status", 32'(status_out), 32'h6);
        check("bubble_wb",     32'(WB_EN_out), 32'h0);

        // Asynchronous reset mid-stream, away from the clock edge
        set_alu(4'b0010, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 4'd3);
        step();
        check("pre_rst_status", 32'(status_out), 32'h9);
        #1;
        rst = 1'b0;
        #1;
        check("rst_alu",    ALU_result_out, 32'h0);
        check("rst_status", 32'(status_out), 32'h0);
        check("rst_wb",     32'(WB_EN_out), 32'h0);
        check("rst_dest",   32'(Dest_out), 32'h0);
        step();
        check("rst_held_freeze_dom", ALU_result_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. Consumes the ID/EX pipeline register outputs.
- Generates the second operand (Val2), performs the ALU operation and computes the branch target.
- Owns the architectural NZCV status register and registers results into the EX/MEM boundary.
- Branch signals are combinational, feeding IF and the flush logic. All other results are registered toward MEM.

Parameters:
- WORD_WIDTH, 32, datapath width
- REG_FILE_DEPTH, 4, destination register index width
- SIGNED_IMM_WIDTH, 24, branch offset width
- SHIFTER_OPERAND_WIDTH, 12, shifter operand field width

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous active-low reset
- freeze  in  1  hold EX/MEM outputs and status register (MEM-side stall)
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Imm_in, B_in, S_in  in  1 each  control bits from ID/EX register
- EX_CMD_in  in  4  ALU command
- Status_Register_in  in  4  NZCV snapshot travelling with the instruction, used for carry-in
- Dest_in  in  REG_FILE_DEPTH  destination register
- signed_immediate_in  in  SIGNED_IMM_WIDTH  branch offset
- shifter_operand_in  in  SHIFTER_OPERAND_WIDTH  operand-2 encoding
- PC_in, Val_Rn_in, Val_Rm_in  in  WORD_WIDTH each  operands
- Branch_taken  out  1  combinational; equals B_in
- Branch_Address  out  WORD_WIDTH  combinational branch target
- status_out  out  4  current NZCV register, to ID condition check
- ALU_result_out  out  WORD_WIDTH  registered ALU result / memory address
- Val_Rm_out  out  WORD_WIDTH  registered store data
- Dest_out  out  REG_FILE_DEPTH  registered destination
- MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1 each  registered control bits

Behaviour:
- **Reset.** rst low, asynchronous: every registered output is 0 and status_out is 4'b0000. Release is synchronous to the next clk edge.

- **Val2 selection:**
  - If Imm_in: imm8 = shifter_operand_in[7:0], zero-extended and rotated right by 2*shifter_operand_in[11:8].
  - Else if MEM_R_EN_in or MEM_W_EN_in: zero-extended shifter_operand_in[11:0].
  - Else: Val_Rm_in shifted by shift_imm = shifter_operand_in[11:7], with type from [6:5]:
    - 00 LSL
    - 01 LSR (logical)
    - 10 ASR (sign-filling)
    - 11 ROR
  - A shift amount of 0 means no shift for all types.

- **ALU commands (EX_CMD_in):**
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2
  - 0011 ADC = Rn+Val2+C
  - 0100 SUB = Rn-Val2
  - 0101 SBC = Rn-Val2-~C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code gives result 0 with flags unchanged-candidate 0.
  - C is taken from Status_Register_in[1]. Bit order is {N,Z,C,V} = [3:0].

- **Flag computation:**
  - N = result[31]; Z = (result == 0).
  - C = carry out of the 33-bit add. For SUB/SBC, C = NOT borrow.
  - V = signed overflow on add/sub. Logical ops and MOV/MVN leave C and V at 0.

- **Status register:**
  - On a posedge with rst high, S_in high and freeze low, NZCV is loaded with the computed flags. Otherwise it holds.
  - CMP/TST arrive as SUB/AND with WB_EN_in=0 and S_in=1. They update flags only.

- **Branch outputs.** Branch_Address = PC_in + (sign-extended signed_immediate_in << 2), computed modulo 2^32.

- **EX/MEM register:**
  - On each posedge with freeze low, it captures ALU_result, Val_Rm_in, Dest_in and the control bits: latency 1 cycle.
  - freeze high holds all registered outputs and the status register. Branch outputs stay combinational.

- **Simultaneous events:**
  - rst low dominates freeze.
  - Bubbles (all control bits 0, as inserted upstream by flush) pass through as zero controls and never touch status.

- Arithmetic wraps at 32 bits. No exceptions are raised.

Test Plan:
- **Reset mid-operation.** Apply reset mid-stream (rst low while WB_EN_in=1) -> all outputs 0 and status_out=0 immediately, without waiting for clk.
- **ADD overflow.** Rn=0x7FFFFFFF, Imm_in=1, shifter=0x001, ADD, S=1 -> ALU_result_out=0x80000000 after 1 edge; status_out=N1 Z0 C0 V1.
- **SUB / CMP:**
  - SUB Rn=5, Val2=5 with S=1 -> result 0, status 0110 (Z=1, C=1).
  - CMP with WB_EN_in=0 -> WB_EN_out=0, flags still updated.
- **Immediate rotate and shifted register:**
  - Imm rotate: shifter=0x2FF -> Val2=0xF000000F.
  - Shifted register ASR: Rm=0x80000000, shifter=0x0C0 (ASR #1) -> MOV result 0xC0000000.
- **Branch target.** B_in=1, PC_in=0x100, offset=0xFFFFFE -> Branch_taken=1, Branch_Address=0x000000F8 in the same cycle.
- **Freeze.** ADD with S=1 presented while freeze=1 for 2 cycles -> outputs and status_out hold their previous values; the update lands on the first edge after freeze drops.
